// File: rtl/chunked_comparator_pkg.sv
// Shared types and constants for the chunked magnitude comparator.
//   state_t : FSM states (IDLE waits for a start chunk, RUN consumes the rest)
//   RES_*   : one-hot result encoding, bit order {eq, gt, lt}
package chunked_comparator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned RES_W = 3;

    localparam logic [RES_W-1:0] RES_NONE = 3'b000;
    localparam logic [RES_W-1:0] RES_EQ   = 3'b100;
    localparam logic [RES_W-1:0] RES_GT   = 3'b010;
    localparam logic [RES_W-1:0] RES_LT   = 3'b001;

endpackage : chunked_comparator_pkg

// File: rtl/chunked_comparator_chunk.sv
// Combinational SIZE-bit comparator for one chunk.
//   a, b      : chunk operands
//   signed_en : 1 = treat a/b as two's complement
//   eq        : a == b
//   gt        : a > b (signed or unsigned per signed_en)
module comparator_chunk #(
    parameter int unsigned SIZE = 5
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            signed_en,
    output logic            eq,
    output logic            gt
);

    always_comb begin
        eq = (a == b);
        if (signed_en) begin
            gt = ($signed(a) > $signed(b));
        end else begin
            gt = (a > b);
        end
    end

endmodule : comparator_chunk

// File: rtl/chunked_comparator.sv
// Serial magnitude comparator for SIZE*WORDS-bit operands, MSB chunk first.
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   start        : with in_valid, marks the first (MSB) chunk
//   in_valid     : A/B chunk accepted this cycle (no backpressure)
//   A, B         : operand chunks
//   signed_mode  : sampled with the start chunk, signed compare of MSB chunk
//   busy         : compare in progress
//   done         : one-cycle pulse, flags updated this cycle
//   aequalsb / agreaterb / alesserb : result of the last completed compare
module chunked_comparator
    import chunked_comparator_pkg::*;
#(
    parameter int unsigned SIZE  = 5,
    parameter int unsigned WORDS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    input  logic            signed_mode,
    output logic            busy,
    output logic            done,
    output logic            aequalsb,
    output logic            agreaterb,
    output logic            alesserb
);

    localparam int unsigned CNT_W = ($clog2(WORDS) > 1) ? $clog2(WORDS) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               decided_q, decided_d;
    logic               gt_q, gt_d;
    logic               done_q, done_d;
    logic [RES_W-1:0]   flags_q, flags_d;

    logic               chunk_eq;
    logic               chunk_gt;

    // Only the MSB chunk (always the start chunk) may compare signed.
    comparator_chunk #(
        .SIZE (SIZE)
    ) u_cmp (
        .a         (A),
        .b         (B),
        .signed_en (start & signed_mode),
        .eq        (chunk_eq),
        .gt        (chunk_gt)
    );

    // Next-state, decision tracking and result formation.
    always_comb begin
        logic finish;
        state_d   = state_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        gt_d      = gt_q;
        done_d    = 1'b0;
        flags_d   = flags_q;
        finish    = 1'b0;

        if (in_valid) begin
            if (start) begin
                // Fresh MSB chunk; in RUN this silently aborts the old compare.
                decided_d = ~chunk_eq;
                gt_d      = chunk_gt;
                if (WORDS == 1) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = RUN;
                    cnt_d   = CNT_W'(1);
                end
            end else if (state_q == RUN) begin
                // First differing chunk wins; later ones are only counted.
                if (!decided_q) begin
                    decided_d = ~chunk_eq;
                    gt_d      = chunk_gt;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WORDS - 1)) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        end

        if (finish) begin
            done_d = 1'b1;
            if (!decided_d) begin
                flags_d = RES_EQ;
            end else if (gt_d) begin
                flags_d = RES_GT;
            end else begin
                flags_d = RES_LT;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            done_q    <= 1'b0;
            flags_q   <= RES_NONE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
            done_q    <= done_d;
            flags_q   <= flags_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign aequalsb  = flags_q[2];
    assign agreaterb = flags_q[1];
    assign alesserb  = flags_q[0];

endmodule : chunked_comparator

// File: tb/tb_chunked_comparator.sv
// Scoreboard bench for chunked_comparator (WORDS=4 and WORDS=1 instances).
module tb_chunked_comparator;

    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_EQ   = 3'b100;
    localparam logic [2:0] F_GT   = 3'b010;
    localparam logic [2:0] F_LT   = 3'b001;

    typedef struct {
        logic [2:0]  flags;
        int unsigned at;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start, in_valid, sm;
    logic [4:0] a, b;
    logic       busy, done, eq, gt, lt;

    logic       start1, in_valid1, sm1;
    logic [4:0] a1, b1;
    logic       busy1, done1, eq1, gt1, lt1;

    chunked_comparator #(.SIZE(5), .WORDS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .A(a), .B(b), .signed_mode(sm), .busy(busy), .done(done),
        .aequalsb(eq), .agreaterb(gt), .alesserb(lt)
    );

    chunked_comparator #(.SIZE(5), .WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1),
        .A(a1), .B(b1), .signed_mode(sm1), .busy(busy1), .done(done1),
        .aequalsb(eq1), .agreaterb(gt1), .alesserb(lt1)
    );

    exp_t        q0[$];
    exp_t        q1[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    logic        mon_en = 1'b0;
    logic [2:0]  hold0 = F_NONE;
    logic [2:0]  hold1 = F_NONE;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the WORDS=4 instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                if (q0.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'(0));
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    check("flags", 32'({eq, gt, lt}), 32'(e.flags));
                    check("done_cycle", 32'(cyc), 32'(e.at));
                    hold0 = e.flags;
                end
            end else begin
                check("flags_hold", 32'({eq, gt, lt}), 32'(hold0));
            end
        end
    end

    // Monitor for the WORDS=1 instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done1) begin
                if (q1.size() == 0) begin
                    check("w1_unexpected_done", 32'(done1), 32'(0));
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    check("w1_flags", 32'({eq1, gt1, lt1}), 32'(e.flags));
                    check("w1_done_cycle", 32'(cyc), 32'(e.at));
                    hold1 = e.flags;
                end
            end else begin
                check("w1_flags_hold", 32'({eq1, gt1, lt1}), 32'(hold1));
            end
        end
    end

    // Drive one chunk; it is accepted at the next posedge. The final chunk's
    // result is expected during the cycle right after the accepting edge.
    task automatic chunk(input logic st, input logic [4:0] xa, input logic [4:0] xb,
                         input logic xs, input logic last, input logic [2:0] res);
        start    = st;
        in_valid = 1'b1;
        a        = xa;
        b        = xb;
        sm       = xs;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
        if (last) q0.push_back('{res, cyc});
    endtask

    task automatic cmp4(input logic [19:0] av, input logic [19:0] bv,
                        input logic xs, input logic [2:0] res);
        for (int i = 0; i < 4; i++) begin
            chunk(i == 0, av[19-5*i -: 5], bv[19-5*i -: 5], xs, i == 3, res);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic one(input logic [4:0] xa, input logic [4:0] xb,
                       input logic xs, input logic [2:0] res);
        start1    = 1'b1;
        in_valid1 = 1'b1;
        a1        = xa;
        b1        = xb;
        sm1       = xs;
        @(posedge clk);
        #1;
        start1    = 1'b0;
        in_valid1 = 1'b0;
        q1.push_back('{res, cyc});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; sm = 1'b0; a = '0; b = '0;
        start1 = 1'b0; in_valid1 = 1'b0; sm1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",  32'(busy), 32'(0));
        check("rst_done",  32'(done), 32'(0));
        check("rst_flags", 32'({eq, gt, lt}), 32'(F_NONE));
        check("rst_w1_flags", 32'({eq1, gt1, lt1}), 32'(F_NONE));
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // All chunks equal.
        cmp4({5'h0A, 5'h0A, 5'h0A, 5'h0A}, {5'h0A, 5'h0A, 5'h0A, 5'h0A}, 1'b0, F_EQ);
        // MSB 0x10 vs 0x0F: unsigned 16>15, signed -16<15 (back-to-back).
        cmp4({5'h10, 5'h00, 5'h00, 5'h00}, {5'h0F, 5'h00, 5'h00, 5'h00}, 1'b0, F_GT);
        cmp4({5'h10, 5'h00, 5'h00, 5'h00}, {5'h0F, 5'h00, 5'h00, 5'h00}, 1'b1, F_LT);
        // Third chunk decides; 31 vs 0 in the last chunk must be ignored.
        cmp4({5'd1, 5'd2, 5'd3, 5'd31}, {5'd1, 5'd2, 5'd7, 5'd0}, 1'b0, F_LT);
        idle(1);

        // Stall between chunks 2 and 3.
        chunk(1'b1, 5'd5, 5'd5, 1'b0, 1'b0, F_NONE);
        chunk(1'b0, 5'd6, 5'd6, 1'b0, 1'b0, F_NONE);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_busy", 32'(busy), 32'(1));
            @(posedge clk);
            #1;
        end
        chunk(1'b0, 5'd9, 5'd4, 1'b0, 1'b0, F_NONE);
        chunk(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, F_GT);
        @(negedge clk);
        check("end_busy", 32'(busy), 32'(0));
        idle(1);

        // Restart after two chunks with a signed MSB: -1 vs 0.
        chunk(1'b1, 5'd7, 5'd7, 1'b0, 1'b0, F_NONE);
        chunk(1'b0, 5'd8, 5'd8, 1'b0, 1'b0, F_NONE);
        chunk(1'b1, 5'h1F, 5'h00, 1'b1, 1'b0, F_NONE);
        chunk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, F_NONE);
        chunk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, F_NONE);
        chunk(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, F_LT);
        idle(2);

        // Reset mid-compare, then a stray chunk without start.
        chunk(1'b1, 5'd3, 5'd3, 1'b0, 1'b0, F_NONE);
        chunk(1'b0, 5'd4, 5'd4, 1'b0, 1'b0, F_NONE);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        hold0 = F_NONE;
        hold1 = F_NONE;
        @(negedge clk);
        check("mid_rst_busy",  32'(busy), 32'(0));
        check("mid_rst_done",  32'(done), 32'(0));
        check("mid_rst_flags", 32'({eq, gt, lt}), 32'(F_NONE));
        @(posedge clk);
        #1;
        chunk(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, F_NONE);
        @(negedge clk);
        check("stray_busy", 32'(busy), 32'(0));
        @(posedge clk);
        #1;
        cmp4({5'd2, 5'd0, 5'd0, 5'd0}, {5'd1, 5'd31, 5'd31, 5'd31}, 1'b0, F_GT);
        idle(1);

        // WORDS=1 instance.
        one(5'd1, 5'd2, 1'b0, F_LT);
        idle(1);
        one(5'd3, 5'd3, 1'b1, F_EQ);
        one(5'h1F, 5'd1, 1'b1, F_LT);
        one(5'h1F, 5'd1, 1'b0, F_GT);
        idle(3);

        check("q0_drained", 32'(q0.size()), 32'(0));
        check("q1_drained", 32'(q1.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_chunked_comparator

// File: doc/chunked_comparator.md
Name: chunked_comparator

Overview:
Magnitude comparator for wide operands of SIZE*WORDS bits, delivered one SIZE-bit chunk per accepted cycle, most-significant chunk first.
- Generalises the combinational SIZE-bit comparator: width is scaled by WORDS, the operation is serialised, and a signed mode is added.
- Produces registered equal/greater/lesser flags plus a one-cycle done pulse.
- Sits between a narrow datapath (bus or serial unpacker) and control logic that needs wide compares without a wide combinational tree.

Parameters:
SIZE, 5, chunk width in bits (>=2)
WORDS, 4, chunks per operand (>=1); operand width = SIZE*WORDS
CNT_W (localparam), max($clog2(WORDS),1), chunk counter width

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  marks the MSB (first) chunk; only meaningful with in_valid
in_valid  input  1  chunk A/B valid this cycle
A  input  SIZE  operand A chunk
B  input  SIZE  operand B chunk
signed_mode  input  1  sampled with the start chunk; 1 = two's-complement operands
busy  output  1  compare in progress (state RUN)
done  output  1  one-cycle pulse, result flags updated this cycle
aequalsb  output  1  A == B (last completed compare)
agreaterb  output  1  A > B
alesserb  output  1  A < B

Behaviour:
- Reset (rst=1 at posedge): state IDLE; counter 0; decided 0; busy, done, aequalsb, agreaterb, alesserb all 0. Takes priority over every other input.
- Accepted chunk: in_valid=1 at a posedge. There is no backpressure; in_valid=0 stalls the compare indefinitely with state held.
- IDLE:
  - in_valid & start: accept the MSB chunk, go to RUN, counter=1.
  - in_valid without start: ignored.
  - If WORDS=1, go directly to result (see below) and stay IDLE.
- MSB chunk comparison: signed when the sampled signed_mode=1; unsigned otherwise. All later chunks always compare unsigned.
- Decision tracking:
  - If the chunks differ, latch decided=1 and gt = (A>B).
  - After decided=1, later chunks are counted but cannot change the result (first differing chunk wins).
- RUN:
  - Each accepted chunk increments the counter.
  - When the chunk with index WORDS-1 is accepted, return to IDLE.
  - In the next cycle: done=1, flags registered as eq = ~decided, gt = decided&gt, lt = decided&~gt.
- Latency: done asserts exactly 1 cycle after the final chunk is accepted (WORDS=1: 1 cycle after the start chunk).
- Restart: start & in_valid while in RUN aborts the current compare without a done pulse. That chunk is treated as a fresh MSB chunk: counter=1, decided cleared, signed_mode resampled.
- Back-to-back: a start chunk accepted in the same cycle that done is high is legal, with no bubble required.
- Flags:
  - Hold their value between done pulses, including while busy.
  - After the first done, exactly one flag is 1.
  - All three flags are 0 only after reset, before any completed compare.
- busy = (state==RUN). done is never high while rst is high.

Decomposition:
- Shared package chunked_comparator_pkg: state enum {IDLE, RUN}; result encoding constants RES_EQ/RES_GT/RES_LT.
- One combinational sub-module, comparator_chunk (SIZE, signed_en input → eq, gt), is instantiated once.
- Top level holds the FSM, counter, decided/gt latch and output registers.

Test Plan:
- (SIZE=5, WORDS=4) All four chunks A=B=5'h0A, no stalls → done 1 cycle after 4th chunk; aequalsb=1, other flags 0.
- MSB A=5'h10, B=5'h0F, rest equal: signed_mode=0 → agreaterb=1; repeat with signed_mode=1 (−16 vs 15) → alesserb=1.
- Chunks equal until 3rd (A=3, B=7), 4th A=31, B=0 → alesserb=1, proving later chunks are ignored once decided.
- in_valid low for 3 cycles between chunks 2 and 3 → busy stays 1, no done until 4th chunk accepted, done exactly 1 cycle later.
- Restart: after 2 chunks, apply start+in_valid with a new MSB → no done for the aborted compare; done 1 cycle after the 4th chunk of the new compare, with the new result.
- rst asserted after 2 chunks → next cycle all outputs 0 and state IDLE; a stray in_valid without start is then ignored. Separate WORDS=1 instance: start+in_valid A=1, B=2 → done next cycle with alesserb=1.
